branch_predictor_hybrid: RTL and testbench

Parametrised next-generation fetch-stage predictor. It combines a bimodal and a gshare direction predictor behind a per-PC selector, with a typed direct-mapped BTB and a return address stack (RAS) for function returns. After reset, a walker FSM clears the tables one entry per cycle. The block sits between the PC register and instruction fetch: prediction is combinational from `PC`, and training comes from the resolve stage.

---
 rtl/branch_predictor_hybrid_pkg.sv | 20 ++
 rtl/adder.sv | 12 +
 rtl/branch_predictor_hybrid_ras.sv | 50 +++++
 rtl/branch_predictor_hybrid.sv | 177 +++++++++++++++++
 tb/tb_branch_predictor_hybrid.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/branch_predictor_hybrid_pkg.sv
// Shared encodings for the hybrid branch predictor: branch types and walker FSM states.
package branch_predictor_hybrid_pkg;

  localparam int unsigned DATA_BUS_BITS = 64;

  // Branch-type encoding as carried by the resolve stage and stored in the BTB.
  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  // INIT walks the tables back to their weak/invalid state; RUN predicts and trains.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/adder.sv
// Plain two-operand adder, used for PC+4 style increments.
module adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/branch_predictor_hybrid_ras.sv
// Circular return address stack; a push when full overwrites the oldest entry.
module return_address_stack #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            nonempty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;   // next free slot; the top lives one below it
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] top_ptr_s;

  assign top_ptr_s = ptr_q - PTR_W'(1);
  assign top       = mem_q[top_ptr_s];
  assign nonempty  = (cnt_q != CNT_W'(0));

  // Pointer and occupancy: count saturates at depth, pop on empty is a no-op.
  always_ff @(negedge clk) begin
    if (reset) begin
      ptr_q <= PTR_W'(0);
      cnt_q <= CNT_W'(0);
    end else if (push) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (pop && nonempty) begin
      ptr_q <= top_ptr_s;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Entry storage; no reset needed because the count masks stale entries.
  always_ff @(negedge clk) begin
    if (!reset && push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/branch_predictor_hybrid.sv
// Hybrid bimodal/gshare direction predictor with per-PC selector, direct-mapped BTB and RAS.
module branch_predictor_hybrid
  import branch_predictor_hybrid_pkg::*;
#(
  parameter int unsigned DataBusBits = DATA_BUS_BITS,
  parameter int unsigned XLEN        = DataBusBits,
  parameter int unsigned IDX_BITS    = 10,
  parameter int unsigned HIST_BITS   = 10,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned RAS_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCPrediction,
  output logic            ready,
  input  logic            we,
  input  logic [XLEN-1:0] PCUpdate,
  input  logic [XLEN-1:0] targetUpdate,
  input  logic            takenUpdate,
  input  logic [1:0]      typeUpdate
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;
  localparam int unsigned TAG_W = XLEN - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  // Saturating step of a direction counter toward the resolved outcome.
  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
    logic [CTR_BITS-1:0] r;
    if (up) r = (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    else    r = (c == CTR_BITS'(0)) ? c : c - CTR_BITS'(1);
    return r;
  endfunction

  logic                btb_valid_q [DEPTH];
  logic [TAG_W-1:0]    btb_tag_q   [DEPTH];
  br_type_e            btb_type_q  [DEPTH];
  logic [XLEN-1:0]     btb_tgt_q   [DEPTH];
  logic [CTR_BITS-1:0] pht1_q      [DEPTH];
  logic [CTR_BITS-1:0] pht2_q      [DEPTH];
  logic [CTR_BITS-1:0] sel_q       [DEPTH];

  fsm_state_e          state_q;
  logic [IDX_BITS-1:0] walk_q;
  logic [HIST_BITS-1:0] ghr_q;

  logic [XLEN-1:0]     ras_top_s, ras_push_data_s;
  logic                ras_nonempty_s, ras_push_s, ras_pop_s;

  // Prediction-side fields.
  logic [IDX_BITS-1:0] p_idx_s, p_gidx_s;
  logic [TAG_W-1:0]    p_tag_s;
  logic                hit_s, pred_taken_s;
  logic [XLEN-1:0]     pred_s;

  // Update-side fields.
  logic [IDX_BITS-1:0] u_idx_s, u_gidx_s;
  logic [TAG_W-1:0]    u_tag_s;
  br_type_e            u_type_s;
  logic                upd_en_s, p1_ok_s, p2_ok_s;

  assign ready    = (state_q == ST_RUN);

  assign p_idx_s  = PC[IDX_BITS+1:2];
  assign p_tag_s  = PC[XLEN-1:IDX_BITS+2];
  assign p_gidx_s = p_idx_s ^ IDX_BITS'(ghr_q);
  assign hit_s    = ready && btb_valid_q[p_idx_s] && (btb_tag_q[p_idx_s] == p_tag_s);
  assign pred_taken_s = sel_q[p_idx_s][CTR_BITS-1] ? pht1_q[p_idx_s][CTR_BITS-1]
                                                   : pht2_q[p_gidx_s][CTR_BITS-1];

  assign u_idx_s  = PCUpdate[IDX_BITS+1:2];
  assign u_tag_s  = PCUpdate[XLEN-1:IDX_BITS+2];
  assign u_gidx_s = u_idx_s ^ IDX_BITS'(ghr_q);
  assign u_type_s = br_type_e'(typeUpdate);
  assign upd_en_s = we && (state_q == ST_RUN);
  assign p1_ok_s  = (pht1_q[u_idx_s][CTR_BITS-1] == takenUpdate);
  assign p2_ok_s  = (pht2_q[u_gidx_s][CTR_BITS-1] == takenUpdate);

  assign ras_push_s = upd_en_s && (u_type_s == BR_CALL);
  assign ras_pop_s  = upd_en_s && (u_type_s == BR_RET);

  adder #(.WIDTH(XLEN)) u_pc_plus4 (
    .a (PC),
    .b (XLEN'(4)),
    .y (PCPlus4)
  );

  adder #(.WIDTH(XLEN)) u_ret_addr (
    .a (PCUpdate),
    .b (XLEN'(4)),
    .y (ras_push_data_s)
  );

  return_address_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (ras_push_data_s),
    .top       (ras_top_s),
    .nonempty  (ras_nonempty_s)
  );

  // Next-PC selection from the BTB hit type and the chosen direction predictor.
  always_comb begin
    pred_s = PCPlus4;
    if (hit_s) begin
      case (btb_type_q[p_idx_s])
        BR_COND: pred_s = pred_taken_s ? btb_tgt_q[p_idx_s] : PCPlus4;
        BR_JUMP: pred_s = btb_tgt_q[p_idx_s];
        BR_CALL: pred_s = btb_tgt_q[p_idx_s];
        BR_RET:  pred_s = ras_nonempty_s ? ras_top_s : btb_tgt_q[p_idx_s];
        default: pred_s = PCPlus4;
      endcase
    end else begin
      pred_s = PCPlus4;
    end
  end

  assign PCPrediction = pred_s;

  // Walker FSM and global history: INIT clears one entry per edge, RUN shifts history on branches.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      walk_q  <= IDX_BITS'(0);
      ghr_q   <= HIST_BITS'(0);
    end else begin
      case (state_q)
        ST_INIT: begin
          walk_q <= walk_q + IDX_BITS'(1);
          if (walk_q == {IDX_BITS{1'b1}}) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (upd_en_s && (u_type_s == BR_COND)) begin
            ghr_q <= HIST_BITS'({ghr_q, takenUpdate});
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Table writes: walker initialisation in INIT, resolve-stage training in RUN.
  always_ff @(negedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        btb_valid_q[walk_q] <= 1'b0;
        pht1_q[walk_q]      <= CTR_INIT;
        pht2_q[walk_q]      <= CTR_INIT;
        sel_q[walk_q]       <= CTR_INIT;
      end else if (upd_en_s) begin
        if (takenUpdate) begin
          btb_valid_q[u_idx_s] <= 1'b1;
          btb_tag_q[u_idx_s]   <= u_tag_s;
          btb_type_q[u_idx_s]  <= u_type_s;
          btb_tgt_q[u_idx_s]   <= targetUpdate;
        end
        if (u_type_s == BR_COND) begin
          pht1_q[u_idx_s]  <= ctr_step(pht1_q[u_idx_s], takenUpdate);
          pht2_q[u_gidx_s] <= ctr_step(pht2_q[u_gidx_s], takenUpdate);
          if (p1_ok_s && !p2_ok_s) begin
            sel_q[u_idx_s] <= ctr_step(sel_q[u_idx_s], 1'b1);
          end else if (!p1_ok_s && p2_ok_s) begin
            sel_q[u_idx_s] <= ctr_step(sel_q[u_idx_s], 1'b0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_hybrid.sv
// Directed self-checking bench for branch_predictor_hybrid (IDX_BITS=4, RAS_DEPTH=4).
module tb_branch_predictor_hybrid;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] PC, PCPlus4, PCPrediction, PCUpdate, targetUpdate;
  logic            ready, we, takenUpdate;
  logic [1:0]      typeUpdate;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  branch_predictor_hybrid #(
    .DataBusBits(64), .XLEN(XLEN), .IDX_BITS(4), .HIST_BITS(4), .CTR_BITS(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .PC(PC), .PCPlus4(PCPlus4), .PCPrediction(PCPrediction),
    .ready(ready), .we(we), .PCUpdate(PCUpdate), .targetUpdate(targetUpdate),
    .takenUpdate(takenUpdate), .typeUpdate(typeUpdate)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts falling edges until ready (bounded); checks PC+4 prediction while walking.
  task automatic wait_ready(output int n);
    bit done;
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      n++;
      if (ready) done = 1'b1;
      else check_eq("walk_pred", PCPrediction, PC + 64'd4);
    end
  endtask

  task automatic do_reset();
    int n;
    @(posedge clk); #1 reset = 1'b1; we = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    wait_ready(n);
    check_eq("walk_len", 64'(n), 64'd16);
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input logic [1:0] ty);
    @(posedge clk); #1;
    we = 1'b1; PCUpdate = pc; targetUpdate = tgt; takenUpdate = tk; typeUpdate = ty;
    @(negedge clk); #1 we = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic [63:0] pc, input logic [63:0] exp);
    PC = pc; #1;
    check_eq(tag, PCPrediction, exp);
  endtask

  initial begin
    int n;
    reset = 1'b1; we = 1'b0; PC = 64'h100;
    PCUpdate = 64'd0; targetUpdate = 64'd0; takenUpdate = 1'b0; typeUpdate = 2'b00;

    // Reset state and walker length.
    @(negedge clk); #1;
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_pc4", PCPlus4, 64'h104);
    check_eq("rst_pred", PCPrediction, 64'h104);
    reset = 1'b0;
    wait_ready(n);
    check_eq("walk_len_first", 64'(n), 64'd16);

    // Reset reasserted mid-walk restarts the count; we is ignored while walking.
    do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    repeat (7) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    we = 1'b1; PCUpdate = 64'h100; targetUpdate = 64'h80; takenUpdate = 1'b1; typeUpdate = 2'b01;
    wait_ready(n);
    we = 1'b0;
    check_eq("walk_restart_len", 64'(n), 64'd16);
    expect_pred("init_ignores_we", 64'h100, 64'h104);

    // Loop branch: bimodal learns taken, then not-taken.
    do_reset();
    repeat (3) upd(64'h100, 64'h80, 1'b1, 2'b00);
    expect_pred("loop_taken", 64'h100, 64'h80);
    repeat (2) upd(64'h100, 64'h80, 1'b0, 2'b00);
    expect_pred("loop_not_taken", 64'h100, 64'h104);

    // Selector training on an alternating branch: gshare takes over.
    do_reset();
    for (int i = 0; i < 8; i++) upd(64'h200, 64'h400, (i % 2 == 0), 2'b00);
    expect_pred("alt_gshare_t", 64'h200, 64'h400);
    upd(64'h200, 64'h400, 1'b1, 2'b00);
    expect_pred("alt_gshare_n", 64'h200, 64'h204);

    // Call/return through the RAS, then fallback to BTB target when empty.
    do_reset();
    upd(64'h1010, 64'h2000, 1'b1, 2'b11);
    expect_pred("ret_empty_btb", 64'h1010, 64'h2000);
    upd(64'h300, 64'h1000, 1'b1, 2'b10);
    expect_pred("call_target", 64'h300, 64'h1000);
    expect_pred("ret_from_ras", 64'h1010, 64'h304);
    upd(64'h1010, 64'h2000, 1'b1, 2'b11);
    expect_pred("ret_after_pop", 64'h1010, 64'h2000);

    // RAS overflow with depth 4: oldest entry lost, extra pop harmless.
    do_reset();
    upd(64'h808, 64'h2000, 1'b1, 2'b11);
    for (int i = 1; i <= 5; i++) upd(64'(i * 16), 64'h900, 1'b1, 2'b10);
    expect_pred("ras_pop1", 64'h808, 64'h54);
    upd(64'h808, 64'h2000, 1'b1, 2'b11);
    expect_pred("ras_pop2", 64'h808, 64'h44);
    upd(64'h808, 64'h2000, 1'b1, 2'b11);
    expect_pred("ras_pop3", 64'h808, 64'h34);
    upd(64'h808, 64'h2000, 1'b1, 2'b11);
    expect_pred("ras_pop4", 64'h808, 64'h24);
    upd(64'h808, 64'h2000, 1'b1, 2'b11);
    expect_pred("ras_empty", 64'h808, 64'h2000);
    upd(64'h808, 64'h2000, 1'b1, 2'b11);
    expect_pred("ras_pop_empty", 64'h808, 64'h2000);

    // Update visibility at the falling edge, then tag alias miss.
    do_reset();
    @(posedge clk); #1;
    PC = 64'h100;
    we = 1'b1; PCUpdate = 64'h100; targetUpdate = 64'h80; takenUpdate = 1'b1; typeUpdate = 2'b01;
    #1 check_eq("pre_edge_old", PCPrediction, 64'h104);
    @(negedge clk); #1 we = 1'b0;
    check_eq("post_edge_new", PCPrediction, 64'h80);
    expect_pred("tag_alias", 64'h140, 64'h144);
    check_eq("alias_pc4", PCPlus4, 64'h144);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
